// File: rtl/lane_merge_scheduler.sv
// Two-lane byte re-merge scheduler: per-lane FIFOs feed a registered output stage.
// Ports: clk_4f/reset, data_inN/valid_inN, mode, pop_ready, data_out/valid_out, pauseN, overflowN, next_lane.
module lane_merge_scheduler #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 2,
  parameter int AF_THRESH = 3
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in0,
  input  logic              valid_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic              valid_in1,
  input  logic              mode,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              pause0,
  output logic              pause1,
  output logic              overflow0,
  output logic              overflow1,
  output logic              next_lane
);

  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q  [2][DEPTH];
  logic [DATA_W-1:0] mem_d  [2][DEPTH];
  logic [ADDR_W-1:0] wptr_q [2];
  logic [ADDR_W-1:0] wptr_d [2];
  logic [ADDR_W-1:0] rptr_q [2];
  logic [ADDR_W-1:0] rptr_d [2];
  logic [CNT_W-1:0]  cnt_q  [2];
  logic [CNT_W-1:0]  cnt_d  [2];
  logic [1:0]        ovf_q, ovf_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              vout_q, vout_d;
  logic              next_q, next_d;

  logic [DATA_W-1:0] din [2];
  logic [1:0]        vin;
  logic [1:0]        full;
  logic [1:0]        nempty;
  logic [1:0]        wr;
  logic [1:0]        pop;
  logic              free;

  always_comb begin
    din[0] = data_in0;
    din[1] = data_in1;
    vin    = {valid_in1, valid_in0};
    for (int l = 0; l < 2; l++) begin
      full[l]   = (cnt_q[l] == CNT_W'(DEPTH));
      nempty[l] = (cnt_q[l] != '0);
    end
    // Full check uses the pre-edge count: a same-edge pop does not make room.
    wr   = vin & ~full;
    free = ~vout_q | pop_ready;

    // Preferred lane first; mode 1 may fall through to the other lane.
    pop = '0;
    if (free) begin
      if (nempty[next_q])
        pop[next_q] = 1'b1;
      else if (mode && nempty[~next_q])
        pop[~next_q] = 1'b1;
    end

    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    for (int l = 0; l < 2; l++) begin
      if (wr[l]) begin
        mem_d[l][wptr_q[l]] = din[l];
        wptr_d[l] = wptr_q[l] + ADDR_W'(1);
      end
      if (pop[l])
        rptr_d[l] = rptr_q[l] + ADDR_W'(1);
      if (wr[l] && !pop[l])
        cnt_d[l] = cnt_q[l] + CNT_W'(1);
      else if (!wr[l] && pop[l])
        cnt_d[l] = cnt_q[l] - CNT_W'(1);
    end

    ovf_d = ovf_q | (vin & full);

    dout_d = dout_q;
    vout_d = vout_q;
    if (free) begin
      vout_d = |pop;
      if (pop[0])
        dout_d = mem_q[0][rptr_q[0]];
      else if (pop[1])
        dout_d = mem_q[1][rptr_q[1]];
    end

    next_d = next_q;
    if (pop[0])
      next_d = 1'b1;
    else if (pop[1])
      next_d = 1'b0;
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < 2; l++) begin
        for (int i = 0; i < DEPTH; i++)
          mem_q[l][i] <= '0;
        wptr_q[l] <= '0;
        rptr_q[l] <= '0;
        cnt_q[l]  <= '0;
      end
      ovf_q  <= '0;
      dout_q <= '0;
      vout_q <= 1'b0;
      next_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      dout_q <= dout_d;
      vout_q <= vout_d;
      next_q <= next_d;
    end
  end

  assign data_out  = dout_q;
  assign valid_out = vout_q;
  assign next_lane = next_q;
  assign overflow0 = ovf_q[0];
  assign overflow1 = ovf_q[1];
  assign pause0    = (cnt_q[0] >= CNT_W'(AF_THRESH));
  assign pause1    = (cnt_q[1] >= CNT_W'(AF_THRESH));

endmodule

// File: tb/tb_lane_merge_scheduler.sv
// Directed bench for lane_merge_scheduler: vector table plus hand sequences.
// Checks ordering, stalls, backpressure, overflow and async reset.
module tb_lane_merge_scheduler;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic [7:0] data_in0, data_in1;
  logic       valid_in0, valid_in1;
  logic       mode, pop_ready;
  logic [7:0] data_out;
  logic       valid_out, pause0, pause1;
  logic       overflow0, overflow1, next_lane;

  int n_chk  = 0;
  int n_fail = 0;

  lane_merge_scheduler dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .data_in0  (data_in0),
    .valid_in0 (valid_in0),
    .data_in1  (data_in1),
    .valid_in1 (valid_in1),
    .mode      (mode),
    .pop_ready (pop_ready),
    .data_out  (data_out),
    .valid_out (valid_out),
    .pause0    (pause0),
    .pause1    (pause1),
    .overflow0 (overflow0),
    .overflow1 (overflow1),
    .next_lane (next_lane)
  );

  always #5 clk_4f = ~clk_4f;

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       md;
    logic       pr;
    logic       ev;
    logic [7:0] ed;
    logic       en;
    logic       ep0;
    logic       eo0;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v0, input logic [7:0] d0,
                     input logic v1, input logic [7:0] d1,
                     input logic md, input logic pr,
                     input logic ev, input logic [7:0] ed,
                     input logic en, input logic ep0,
                     input logic eo0);
    vec_t r;
    r.v0 = v0; r.d0 = d0; r.v1 = v1; r.d1 = d1;
    r.md = md; r.pr = pr; r.ev = ev; r.ed = ed;
    r.en = en; r.ep0 = ep0; r.eo0 = eo0;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1,
                       input logic md, input logic pr);
    valid_in0 = v0; data_in0 = d0;
    valid_in1 = v1; data_in1 = d1;
    mode = md; pop_ready = pr;
  endtask

  task automatic tick;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic ev,
                            input logic [7:0] ed, input logic en,
                            input logic ep0, input logic eo0);
    chk({tag, ".valid"}, {7'b0, valid_out}, {7'b0, ev});
    chk({tag, ".data"}, data_out, ed);
    chk({tag, ".next"}, {7'b0, next_lane}, {7'b0, en});
    chk({tag, ".pause0"}, {7'b0, pause0}, {7'b0, ep0});
    chk({tag, ".pause1"}, {7'b0, pause1}, 8'h00);
    chk({tag, ".ovf0"}, {7'b0, overflow0}, {7'b0, eo0});
    chk({tag, ".ovf1"}, {7'b0, overflow1}, 8'h00);
  endtask

  initial begin
    // strict order
    add(1,8'hA0,1,8'hB0,0,1, 0,8'h00,0,0,0);
    add(1,8'hA1,1,8'hB1,0,1, 1,8'hA0,1,0,0);
    add(0,8'h00,0,8'h00,0,1, 1,8'hB0,0,0,0);
    add(0,8'h00,0,8'h00,0,1, 1,8'hA1,1,0,0);
    add(0,8'h00,0,8'h00,0,1, 1,8'hB1,0,0,0);
    add(0,8'h00,0,8'h00,0,1, 0,8'hB1,0,0,0);
    // strict stall
    add(1,8'h11,0,8'h00,0,1, 0,8'hB1,0,0,0);
    add(1,8'h22,0,8'h00,0,1, 1,8'h11,1,0,0);
    add(0,8'h00,0,8'h00,0,1, 0,8'h11,1,0,0);
    add(0,8'h00,0,8'h00,0,1, 0,8'h11,1,0,0);
    add(0,8'h00,1,8'h33,0,1, 0,8'h11,1,0,0);
    add(0,8'h00,0,8'h00,0,1, 1,8'h33,0,0,0);
    add(0,8'h00,0,8'h00,0,1, 1,8'h22,1,0,0);
    add(0,8'h00,0,8'h00,0,1, 0,8'h22,1,0,0);
    // work-conserving
    add(1,8'h11,0,8'h00,1,1, 0,8'h22,1,0,0);
    add(1,8'h22,0,8'h00,1,1, 1,8'h11,1,0,0);
    add(0,8'h00,0,8'h00,1,1, 1,8'h22,1,0,0);
    add(0,8'h00,1,8'h33,1,1, 0,8'h22,1,0,0);
    add(0,8'h00,0,8'h00,1,1, 1,8'h33,0,0,0);
    add(0,8'h00,0,8'h00,1,1, 0,8'h33,0,0,0);
    // backpressure and overflow
    add(1,8'h01,0,8'h00,1,0, 0,8'h33,0,0,0);
    add(1,8'h02,0,8'h00,1,0, 1,8'h01,1,0,0);
    add(1,8'h03,0,8'h00,1,0, 1,8'h01,1,0,0);
    add(1,8'h04,0,8'h00,1,0, 1,8'h01,1,1,0);
    add(1,8'h05,0,8'h00,1,0, 1,8'h01,1,1,0);
    add(1,8'h06,0,8'h00,1,0, 1,8'h01,1,1,1);
    add(0,8'h00,0,8'h00,1,1, 1,8'h02,1,1,1);
    add(0,8'h00,0,8'h00,1,1, 1,8'h03,1,0,1);
    add(0,8'h00,0,8'h00,1,1, 1,8'h04,1,0,1);
    add(0,8'h00,0,8'h00,1,1, 1,8'h05,1,0,1);
    add(0,8'h00,0,8'h00,1,1, 0,8'h05,1,0,1);

    drive(0,8'h00,0,8'h00,0,1);
    reset = 1'b1;
    #1;
    expect_out("por", 0, 8'h00, 0, 0, 0);
    tick;
    tick;
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1,
            tbl[i].md, tbl[i].pr);
      tick;
      expect_out($sformatf("row%0d", i), tbl[i].ev, tbl[i].ed,
                 tbl[i].en, tbl[i].ep0, tbl[i].eo0);
    end

    // full lane0 written on the same edge it is popped
    reset = 1'b1;
    #2;
    reset = 1'b0;
    drive(1,8'hC0,0,8'h00,1,0); tick;
    drive(1,8'hC1,0,8'h00,1,0); tick;
    drive(1,8'hC2,0,8'h00,1,0); tick;
    drive(1,8'hC3,0,8'h00,1,0); tick;
    drive(1,8'hC4,0,8'h00,1,0); tick;
    expect_out("full", 1, 8'hC0, 1, 1, 0);
    drive(1,8'hC5,0,8'h00,1,1); tick;
    expect_out("fullpop", 1, 8'hC1, 1, 1, 1);
    drive(0,8'h00,0,8'h00,1,1); tick;
    expect_out("drain0", 1, 8'hC2, 1, 0, 1);
    tick;
    expect_out("drain1", 1, 8'hC3, 1, 0, 1);
    tick;
    expect_out("drain2", 1, 8'hC4, 1, 0, 1);
    tick;
    expect_out("drain3", 0, 8'hC4, 1, 0, 1);

    // reset mid-stream with data buffered in both lanes
    drive(1,8'hD0,1,8'hE0,0,0); tick;
    drive(1,8'hD1,0,8'h00,0,0); tick;
    expect_out("pre_a", 1, 8'hE0, 0, 0, 1);
    drive(0,8'h00,1,8'hE1,0,0); tick;
    expect_out("pre_b", 1, 8'hE0, 0, 0, 1);
    drive(0,8'h00,0,8'h00,0,1);
    #2;
    reset = 1'b1;
    #1;
    expect_out("async_rst", 0, 8'h00, 0, 0, 0);
    tick;
    reset = 1'b0;
    drive(1,8'h5A,1,8'hA5,0,1); tick;
    expect_out("post_w", 0, 8'h00, 0, 0, 0);
    drive(0,8'h00,0,8'h00,0,1); tick;
    expect_out("post_0", 1, 8'h5A, 1, 0, 0);
    tick;
    expect_out("post_1", 1, 8'hA5, 0, 0, 0);
    tick;
    expect_out("post_2", 0, 8'hA5, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_merge_scheduler.md
Name: lane_merge_scheduler

Overview:
Scheduler that re-merges two 8-bit lane streams (lane 0 / lane 1, as produced by the 1x2 byte-striping demux) into one byte stream on clk_4f. Each lane has a small FIFO. A pointer-based scheduler selects which FIFO is popped into a registered output stage. It supports strict alternation, which preserves striping order, and a work-conserving round-robin. Per-lane pause and overflow flags feed back to the lane sources.

Parameters:
DATA_W, 8, byte width of every data path
DEPTH, 4, entries per lane FIFO
ADDR_W, 2, log2(DEPTH); FIFO pointer width
AF_THRESH, 3, occupancy at or above which pauseN asserts

Ports:
clk_4f  in  1  single clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
data_in0  in  DATA_W  lane 0 byte
valid_in0  in  1  lane 0 byte valid
data_in1  in  DATA_W  lane 1 byte
valid_in1  in  1  lane 1 byte valid
mode  in  1  0 = strict alternate, 1 = work-conserving round-robin
pop_ready  in  1  downstream accepts data_out this cycle
data_out  out  DATA_W  merged byte (registered)
valid_out  out  1  data_out valid (registered)
pause0  out  1  lane 0 FIFO count >= AF_THRESH
pause1  out  1  lane 1 FIFO count >= AF_THRESH
overflow0  out  1  sticky: lane 0 byte dropped
overflow1  out  1  sticky: lane 1 byte dropped
next_lane  out  1  scheduler pointer (lane to be preferred next)

Behaviour:
- Reset (async, any time, including mid-stream): FIFO pointers and counts = 0, next_lane = 0, data_out = 0, valid_out = 0, overflow0/1 = 0, pause0/1 = 0. All FIFO contents are discarded. The first post-reset pop comes from lane 0's first new byte (strict mode).
- FIFO write: on an edge with validN=1 and countN<DEPTH, the byte is stored.
  - If countN==DEPTH (pre-edge value), the byte is dropped and overflowN is set. The drop happens even if the same lane is popped on that edge.
- FIFO count: +1 on write, -1 on pop, unchanged on both or neither. Pointers wrap modulo DEPTH.
- pauseN: combinational decode of the countN register (countN >= AF_THRESH).
- Output stage is "free" when valid_out==0 or pop_ready==1.
  - Free: the scheduler may pop one byte into data_out and set valid_out=1. If nothing is popped, valid_out=0 and data_out holds its last value.
  - Not free: data_out and valid_out hold, and no pop occurs.
- Latency: a byte written at edge N can appear on data_out at edge N+1 at the earliest. There is no bypass.
- Scheduler, strict mode (mode=0):
  - Pop only from lane next_lane, and only if that FIFO is non-empty.
  - Otherwise stall: no pop, even if the other lane has data.
- Scheduler, work-conserving mode (mode=1):
  - If lane next_lane is non-empty, pop it.
  - Else, if the other lane is non-empty, pop the other lane.
  - Else, no pop.
- Pointer update in both modes: after serving lane L, next_lane = ~L. It is unchanged when nothing is popped.
- mode is sampled every edge and takes effect immediately; next_lane is preserved across mode changes.
- The overflow flags clear only on reset.

Test Plan:
1. Reset mid-operation: fill lane0 with 2 bytes, lane1 with 1, then assert reset between edges. Required: all outputs 0 immediately, with no clock edge needed. After release, new lane0 0x5A and lane1 0xA5 give output 0x5A then 0xA5.
2. Strict order, mode=0, pop_ready=1: lane0 gets 0xA0, 0xA1 and lane1 gets 0xB0, 0xB1 on the same two edges. Required: data_out = 0xA0, 0xB0, 0xA1, 0xB1 on consecutive cycles; first valid one edge after the first write.
3. Strict stall, mode=0: only lane0 gets 0x11, 0x22. Required: 0x11 is output, then valid_out=0 with next_lane=1. When lane1 later gets 0x33, the output is 0x33 then 0x22.
4. Work-conserving, mode=1, same stimulus as scenario 3. Required: 0x11 and 0x22 on consecutive cycles; later 0x33 is output; next_lane=0 afterwards.
5. Backpressure, mode=1, pop_ready=0: lane0 gets 0x01..0x06 on 6 consecutive edges.
   - 0x01 is latched in data_out; 0x02..0x05 fill the FIFO.
   - pause0 rises after the 0x04 write (count=3).
   - 0x06 is dropped and overflow0=1.
   - When pop_ready is raised, 0x01..0x05 stream out and 0x06 never appears.
6. Simultaneous full write and pop: lane0 is full, pop_ready=1, lane0 is popped on the same edge as a new write. Required: the new byte is dropped, overflow0=1, and count goes 4 -> 3.
